seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//   Runtime-programmable serial pattern detector; generalised successor to the fixed 4-bit FSM detectors.
//   Detects a pattern of 1..MAX_LEN bits, MSB-first, on a valid-qualified serial stream.
//   Overlapping or non-overlapping mode. Mealy match pulse plus registered copy. Saturating match counter.
//   Sits between a serial bit source and status/interrupt logic.
// PARAMETERS
//   MAX_LEN  8   maximum pattern length in bits (>=2)
//   LEN_W    $clog2(MAX_LEN+1)   width of the length field
//   CNT_W    16  match counter width
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        reset, asynchronous, active-low
//   cfg_load   in   1        latch cfg_pattern/cfg_len/cfg_overlap; clear history
//   cfg_pattern in  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit expected
//   cfg_len    in   LEN_W    pattern length
//   cfg_overlap in  1        1 = overlapping, 0 = non-overlapping
//   en         in   1        detector enable; 0 = freeze history and counter
//   x_valid    in   1        x carries a new serial bit this cycle
//   x          in   1        serial data bit
//   cnt_clr    in   1        synchronous clear of match_cnt
//   match      out  1        Mealy: high in the cycle the final pattern bit is presented
//   match_q    out  1        match registered (1-cycle latency)
//   match_cnt  out  CNT_W    matches since reset or cnt_clr; saturates at all-ones
// BEHAVIOUR
//   Reset values:
//     - pattern = 0, len = 1, overlap = 1.
//     - history = 0, fill = 0, match_q = 0, match_cnt = 0.
//     - match = 0 (no x_valid is qualified during reset).
//   Config:
//     - On cfg_load, active-config registers update at the clock edge.
//     - cfg_len = 0 is stored as 1; cfg_len > MAX_LEN is stored as MAX_LEN.
//     - History and fill clear on the same edge.
//     - cfg_load has priority over a concurrent x_valid: that bit is dropped and match = 0.
//   Shift: a bit is accepted when en & x_valid & !cfg_load.
//     - hist <= {hist[MAX_LEN-2:0], x} (MAX_LEN-1 bit history).
//     - fill <= min(fill+1, MAX_LEN-1).
//   Match: match = accepted & (fill >= len-1) & ({hist, x} low len bits == pattern low len bits).
//     - match is combinational from x and x_valid; no added latency.
//     - len = 1 matches every accepted bit equal to pattern[0].
//   After a match:
//     - Overlapping: shift as normal, so the suffix is reused (1010 on 1010101 -> 2 matches).
//     - Non-overlapping: hist and fill clear on the match edge instead of shifting (same stream -> 1 match).
//   match_q <= match every cycle, including while en = 0 (match is then 0).
//   Counter:
//     - cnt_clr has priority: match_cnt <= 0 even if match is high that cycle.
//     - Otherwise match_cnt increments on match and holds at 2^CNT_W-1.
//   en = 0:
//     - No shift, match = 0, counter holds.
//     - The history stays valid, so a pattern may span an enable gap.
//   Bubbles (x_valid = 0) do not disturb the history; the pattern is matched over accepted bits only.
//   Reset mid-stream: all state returns to reset values immediately (async).
//     - Reset reverts the configuration to the defaults, so software reloads it.
// TESTING
//   T1 Reset; load 4'b1010, len 4, overlap 1. Stream 1,0,1,0,1,0 -> match on bits 4 and 6; match_q one cycle later; cnt = 2.
//   T2 Same stream with overlap 0 -> match on bit 4 only; cnt = 1. Further 1,0,1,0 -> second match; cnt = 2.
//   T3 len 8, pattern 8'hA5. Stream with bubbles and en low mid-pattern -> exactly one match, on the last accepted bit.
//   T4 cfg_len = 0 then 15 (MAX_LEN 8) -> stored as 1 and 8. len 1, pattern 1: stream 1,1,0,1 -> 3 matches.
//   T5 CNT_W = 2, 5 matches -> cnt saturates at 3. cnt_clr coincident with a match -> cnt = 0.
//   T6 Assert rst_n low mid-pattern (after 1,0,1), then reload the config and send 0 -> no match.
//      Also cfg_load coincident with the final bit -> no match, and fill = 0 on the next cycle.

Source files
------------

// File: rtl/seq_detect_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param_if
//  Description : Bundle of configuration, serial-stream and status signals
//                for the programmable serial pattern detector.
//                  master : bit source / software side (drives config + bits)
//                  slave  : detector side (drives match / match_q / match_cnt)
//                Signals:
//                  cfg_load, cfg_pattern, cfg_len, cfg_overlap  configuration
//                  en, x_valid, x                               serial stream
//                  cnt_clr                                      counter clear
//                  match, match_q, match_cnt                    status
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_detect_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 16
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               en;
    logic               x_valid;
    logic               x;
    logic               cnt_clr;
    logic               match;
    logic               match_q;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output en, x_valid, x, cnt_clr,
        input  match, match_q, match_cnt
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  en, x_valid, x, cnt_clr,
        output match, match_q, match_cnt
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Runtime-programmable serial pattern detector. Recognises a
//                pattern of 1..MAX_LEN bits (MSB first) on a valid-qualified
//                serial stream, in overlapping or non-overlapping mode.
//                Produces a Mealy match pulse, a registered copy of it, and
//                a saturating match counter.
//  Ports       :
//    clk                 in   rising-edge clock
//    rst_n               in   asynchronous active-low reset
//    bus.cfg_load        in   latch cfg_pattern/cfg_len/cfg_overlap, clear history
//    bus.cfg_pattern     in   pattern, right-aligned; bit [len-1] arrives first
//    bus.cfg_len         in   pattern length (0 -> 1, >MAX_LEN -> MAX_LEN)
//    bus.cfg_overlap     in   1 = overlapping, 0 = non-overlapping
//    bus.en              in   detector enable; 0 freezes history and counter
//    bus.x_valid         in   x carries a new serial bit this cycle
//    bus.x               in   serial data bit
//    bus.cnt_clr         in   synchronous clear of match_cnt
//    bus.match           out  combinational match on the final pattern bit
//    bus.match_q         out  match delayed by one clock
//    bus.match_cnt       out  saturating count of matches
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_detect_param_if.slave   bus
);

    localparam logic [LEN_W-1:0] c_len_one  = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_len_max  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_fill_max = LEN_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // Active configuration
    // ------------------------------------------------------------------------
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;

    // ------------------------------------------------------------------------
    // Stream history: the last MAX_LEN-1 accepted bits (newest in bit 0) and
    // how many of them are meaningful since the last clear.
    // ------------------------------------------------------------------------
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;

    logic               r_match_q;
    logic [CNT_W-1:0]   r_match_cnt;

    logic [LEN_W-1:0]   w_len_clamped;
    logic               w_accept;
    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_pat_eq;
    logic               w_fill_ok;
    logic               w_match;
    logic [MAX_LEN-2:0] w_hist_shift;
    logic [LEN_W-1:0]   w_fill_next;

    // Out-of-range lengths are folded into the legal 1..MAX_LEN range so the
    // compare logic never has to handle an empty or oversized window.
    always_comb begin
        w_len_clamped = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            w_len_clamped = c_len_one;
        end else if (bus.cfg_len > c_len_max) begin
            w_len_clamped = c_len_max;
        end
    end

    // A configuration load wins over a bit arriving in the same cycle; that
    // bit is discarded rather than being applied to the old or new pattern.
    assign w_accept = bus.en & bus.x_valid & ~bus.cfg_load;

    // The current bit completes the window, so the match is available in the
    // same cycle the final bit is presented.
    assign w_window = {r_hist, bus.x};

    // Only the low r_len bits of the window take part in the compare.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign w_mask[gi] = (r_len > LEN_W'(gi));
    end

    assign w_pat_eq  = (((w_window ^ r_pattern) & w_mask) == '0);
    assign w_fill_ok = (r_fill >= (r_len - c_len_one));
    assign w_match   = w_accept & w_fill_ok & w_pat_eq;

    // Shift the new bit into the history. With a two-bit maximum the history
    // is a single bit and simply takes the new bit.
    if (MAX_LEN > 2) begin : g_hist_wide
        assign w_hist_shift = {r_hist[MAX_LEN-3:0], bus.x};
    end else begin : g_hist_single
        assign w_hist_shift = bus.x;
    end

    assign w_fill_next = (r_fill == c_fill_max) ? r_fill : (r_fill + c_len_one);

    // ------------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern <= '0;
            r_len     <= c_len_one;
            r_overlap <= 1'b1;
        end else if (bus.cfg_load) begin
            r_pattern <= bus.cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= bus.cfg_overlap;
        end
    end

    // ------------------------------------------------------------------------
    // History / fill tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (bus.cfg_load) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_accept) begin
            if (w_match && !r_overlap) begin
                // Non-overlapping: the bits that formed this match may not be
                // reused, so the next match starts from an empty history.
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_hist_shift;
                r_fill <= w_fill_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered match copy and saturating counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_q   <= 1'b0;
            r_match_cnt <= '0;
        end else begin
            r_match_q <= w_match;
            if (bus.cnt_clr) begin
                r_match_cnt <= '0;
            end else if (w_match && (r_match_cnt != c_cnt_max)) begin
                r_match_cnt <= r_match_cnt + 1'b1;
            end
        end
    end

    assign bus.match     = w_match;
    assign bus.match_q   = r_match_q;
    assign bus.match_cnt = r_match_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Self-checking bench for seq_detect_param. Two instances
//                (16-bit and 2-bit counters) share one stimulus stream and
//                are compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic             en_s = 1'b0, xv_s = 1'b0, x_s = 1'b0;
    logic             load_s = 1'b0, clr_s = 1'b0, ovl_s = 1'b1;
    logic [7:0]       pat_s = '0;
    logic [LEN_W-1:0] len_s = '0;

    seq_detect_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(16)) bus16 ();
    seq_detect_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2))  bus2  ();

    assign bus16.cfg_load    = load_s;
    assign bus16.cfg_pattern = pat_s;
    assign bus16.cfg_len     = len_s;
    assign bus16.cfg_overlap = ovl_s;
    assign bus16.en          = en_s;
    assign bus16.x_valid     = xv_s;
    assign bus16.x           = x_s;
    assign bus16.cnt_clr     = clr_s;

    assign bus2.cfg_load     = load_s;
    assign bus2.cfg_pattern  = pat_s;
    assign bus2.cfg_len      = len_s;
    assign bus2.cfg_overlap  = ovl_s;
    assign bus2.en           = en_s;
    assign bus2.x_valid      = xv_s;
    assign bus2.x            = x_s;
    assign bus2.cnt_clr      = clr_s;

    seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: list of accepted bits since the history was last
    // cleared, plus the active configuration and counters.
    // ------------------------------------------------------------------------
    bit         mq[$];
    logic [7:0] m_pattern;
    int         m_len;
    bit         m_overlap;
    int         m_cnt16, m_cnt2;
    bit         m_match_q;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  last_match;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit model_match(input bit en_i, input bit xv_i, input bit x_i, input bit load_i);
        bit b;
        if (!(en_i && xv_i && !load_i)) return 1'b0;
        if (mq.size() + 1 < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            b = (i == 0) ? x_i : mq[mq.size() - i];
            if (b != m_pattern[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int clamp_len(input logic [LEN_W-1:0] l);
        if (l == 0) return 1;
        if (int'(l) > MAX_LEN) return MAX_LEN;
        return int'(l);
    endfunction

    task automatic model_reset();
        m_pattern = '0;
        m_len     = 1;
        m_overlap = 1'b1;
        mq.delete();
        m_cnt16   = 0;
        m_cnt2    = 0;
        m_match_q = 1'b0;
    endtask

    // One clock of stimulus. Entered and left 1 time unit after a rising edge.
    task automatic step(input bit en_i, input bit xv_i, input bit x_i, input bit load_i, input bit clr_i);
        bit exp_m;
        en_s = en_i; xv_s = xv_i; x_s = x_i; load_s = load_i; clr_s = clr_i;
        @(negedge clk);
        exp_m = model_match(en_i, xv_i, x_i, load_i);
        last_match = bus16.match;
        chk("match", bus16.match, exp_m);
        chk("match_c2", bus2.match, exp_m);
        @(posedge clk);
        #1;
        if (clr_i) begin
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (exp_m) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        m_match_q = exp_m;
        if (load_i) begin
            m_pattern = pat_s;
            m_len     = clamp_len(len_s);
            m_overlap = ovl_s;
            mq.delete();
        end else if (en_i && xv_i) begin
            if (exp_m && !m_overlap) begin
                mq.delete();
            end else begin
                mq.push_back(x_i);
                if (mq.size() > 16) void'(mq.pop_front());
            end
        end
        chk("match_q", bus16.match_q, m_match_q);
        chk("match_q_c2", bus2.match_q, m_match_q);
        chk("cnt16", bus16.match_cnt, m_cnt16);
        chk("cnt2", bus2.match_cnt, m_cnt2);
        en_s = 0; xv_s = 0; x_s = 0; load_s = 0; clr_s = 0;
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        en_s = 0; xv_s = 0; x_s = 0; load_s = 0; clr_s = 0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_match", bus16.match, 0);
        chk("rst_match_q", bus16.match_q, 0);
        chk("rst_cnt16", bus16.match_cnt, 0);
        chk("rst_cnt2", bus2.match_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [LEN_W-1:0] len, input bit ovl);
        pat_s = pat; len_s = len; ovl_s = ovl;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic send(input bit b);
        step(1'b1, 1'b1, b, 1'b0, 1'b0);
    endtask

    logic [5:0] mvec;
    logic [2:0] t3_tab [12];

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // T1: 1010 overlapping on 101010
        load_cfg(8'h0A, 4'd4, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send(i[0] == 1'b0);
            mvec[i] = last_match;
        end
        chk("t1_vec", mvec, 6'b101000);
        chk("t1_cnt", bus16.match_cnt, 2);

        // T2: non-overlapping
        load_cfg(8'h0A, 4'd4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send(i[0] == 1'b0);
            mvec[i] = last_match;
        end
        chk("t2_vec", mvec, 6'b001000);
        chk("t2_cnt1", bus16.match_cnt, 1);
        for (int i = 0; i < 4; i++) send(i[0] == 1'b0);
        chk("t2_cnt2", bus16.match_cnt, 2);

        // T3: 8-bit A5 with bubbles and enable gaps; entries are {en, x_valid, x}
        t3_tab = '{3'b111, 3'b100, 3'b110, 3'b011, 3'b111, 3'b110,
                   3'b000, 3'b110, 3'b101, 3'b111, 3'b110, 3'b111};
        load_cfg(8'hA5, 4'd8, 1'b1);
        for (int i = 0; i < 12; i++) step(t3_tab[i][2], t3_tab[i][1], t3_tab[i][0], 1'b0, 1'b0);
        chk("t3_last", last_match, 1);
        chk("t3_cnt", bus16.match_cnt, 1);

        // T4: length clamping
        load_cfg(8'h01, 4'd0, 1'b1);
        send(1); send(1); send(0); send(1);
        chk("t4_len0_cnt", bus16.match_cnt, 3);
        load_cfg(8'hFF, 4'd15, 1'b1);
        for (int i = 0; i < 7; i++) send(1);
        chk("t4_len15_pre", bus16.match_cnt, 0);
        send(1);
        chk("t4_len15_cnt", bus16.match_cnt, 1);

        // T5: saturation of the 2-bit counter, clear beats match
        load_cfg(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) send(1);
        chk("t5_sat2", bus2.match_cnt, 3);
        chk("t5_cnt16", bus16.match_cnt, 5);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_clr_match", last_match, 1);
        chk("t5_clr2", bus2.match_cnt, 0);
        chk("t5_clr16", bus16.match_cnt, 0);

        // T6: reset mid-pattern, then cfg_load coincident with final bit
        load_cfg(8'h0A, 4'd4, 1'b1);
        send(1); send(0); send(1);
        do_reset();
        load_cfg(8'h0A, 4'd4, 1'b1);
        send(0);
        chk("t6_after_rst", last_match, 0);
        load_cfg(8'h0A, 4'd4, 1'b1);
        send(1); send(0); send(1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t6_load_final", last_match, 0);
        send(0);
        chk("t6_fill_clear", last_match, 0);

        // Randomised phase
        for (int n = 0; n < 3000; n++) begin
            int r;
            if (n % 700 == 699) do_reset();
            r = $urandom_range(0, 39);
            if (r == 0) begin
                int lr;
                lr = $urandom_range(0, 19);
                if (lr == 0) len_s = '0;
                else if (lr == 1) len_s = LEN_W'($urandom_range(8, 15));
                else len_s = LEN_W'($urandom_range(1, 4));
                pat_s = 8'($urandom);
                ovl_s = 1'($urandom);
                step(1'($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), 1'b1,
                     1'($urandom_range(0, 3) == 0));
            end else begin
                step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                     1'b0, 1'($urandom_range(0, 49) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
